// File: rtl/block_sad_search.sv
// Stereo block matcher: latches a 6x6 left block, streams MAX_DISP right candidates through a
// three-stage |L-R| / row-sum / total pipeline and reports the lowest-SAD candidate index.
module block_sad_search #(
  parameter int BLOCK_SIZE = 6,
  parameter int PIX_W      = 8,
  parameter int MAX_DISP   = 16,
  parameter int SAD_W      = 14,
  localparam int DW        = $clog2(MAX_DISP),
  localparam int ROW_W     = BLOCK_SIZE * PIX_W,
  localparam int RS_W      = PIX_W + 3
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [BLOCK_SIZE-1:0][ROW_W-1:0]    left_block_in,
  input  logic                                left_valid_in,
  input  logic [BLOCK_SIZE-1:0][ROW_W-1:0]    cand_block_in,
  input  logic                                cand_valid_in,
  output logic                                cand_ready_out,
  output logic                                busy_out,
  output logic [DW-1:0]                       disparity_out,
  output logic [SAD_W-1:0]                    best_sad_out,
  output logic                                valid_out
);

  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [DW-1:0]                      cnt_q, cnt_d;
  logic [BLOCK_SIZE-1:0][ROW_W-1:0]   left_q, left_d;
  logic [SAD_W-1:0]                   best_sad_q, best_sad_d;
  logic [DW-1:0]                      best_idx_q, best_idx_d;
  logic [DW-1:0]                      disp_q, disp_d;
  logic [SAD_W-1:0]                   out_sad_q, out_sad_d;
  logic                               valid_q, valid_d;

  logic                               s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [DW-1:0]                      s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d, s3_idx_q, s3_idx_d;
  logic [PIX_W-1:0]                   absd_q [BLOCK_SIZE][BLOCK_SIZE];
  logic [PIX_W-1:0]                   absd_d [BLOCK_SIZE][BLOCK_SIZE];
  logic [RS_W-1:0]                    rs_q [BLOCK_SIZE];
  logic [RS_W-1:0]                    rs_d [BLOCK_SIZE];
  logic [SAD_W-1:0]                   sad_q, sad_d;

  logic                               accept;

  assign accept         = (state_q == ACCEPT) && cand_valid_in;
  assign cand_ready_out = (state_q == ACCEPT);
  assign busy_out       = (state_q != IDLE);
  assign disparity_out  = disp_q;
  assign best_sad_out   = out_sad_q;
  assign valid_out      = valid_q;

  always_comb begin
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        logic [PIX_W-1:0] pl;
        logic [PIX_W-1:0] pr;
        pl = left_q[r][PIX_W*j +: PIX_W];
        pr = cand_block_in[r][PIX_W*j +: PIX_W];
        absd_d[r][j] = (pl > pr) ? (pl - pr) : (pr - pl);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      rs_d[r] = '0;
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        rs_d[r] = rs_d[r] + RS_W'(absd_q[r][j]);
      end
    end
    sad_d = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      sad_d = sad_d + SAD_W'(rs_q[r]);
    end
  end

  always_comb begin
    s1_v_d   = accept;
    s1_idx_d = cnt_q;
    s2_v_d   = s1_v_q;
    s2_idx_d = s1_idx_q;
    s3_v_d   = s2_v_q;
    s3_idx_d = s2_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    disp_d     = disp_q;
    out_sad_d  = out_sad_q;
    valid_d    = 1'b0;

    // Strict less-than keeps the earlier (lower) disparity on ties.
    if (s3_v_q && (sad_q < best_sad_q)) begin
      best_sad_d = sad_q;
      best_idx_d = s3_idx_q;
    end

    case (state_q)
      IDLE: begin
        if (left_valid_in) begin
          left_d     = left_block_in;
          cnt_d      = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          state_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        if (cand_valid_in) begin
          if (cnt_q == DW'(MAX_DISP - 1)) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Stage 3 is compared on the same edge that enters DONE, so only stages 1-2 must be empty.
        if (!s1_v_q && !s2_v_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d   = 1'b1;
        disp_d    = best_idx_q;
        out_sad_d = best_sad_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      left_q     <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      disp_q     <= '0;
      out_sad_q  <= '0;
      valid_q    <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      disp_q     <= disp_d;
      out_sad_q  <= out_sad_d;
      valid_q    <= valid_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s3_v_q     <= s3_v_d;
    end
  end

  // Datapath registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk_in) begin
    absd_q   <= absd_d;
    rs_q     <= rs_d;
    sad_q    <= sad_d;
    s1_idx_q <= s1_idx_d;
    s2_idx_q <= s2_idx_d;
    s3_idx_q <= s3_idx_d;
  end

endmodule
